// File: rtl/easyaxi_slv_rd_engine_pkg.sv
// Shared definitions for the slave-side AXI read-data engine.
//   - AXI burst-type and response encodings
//   - Bit offsets of the packed read descriptor {id, addr, len, size[2:0], burst[1:0]}
//   - Engine state encoding
package easyaxi_slv_rd_engine_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Descriptor layout, LSB first: burst, size, len, addr, id.
  localparam int DESC_BURST_LSB = 0;
  localparam int DESC_SIZE_LSB  = 2;
  localparam int DESC_LEN_LSB   = 5;

  function automatic int desc_addr_lsb(input int len_w);
    return DESC_LEN_LSB + len_w;
  endfunction

  function automatic int desc_id_lsb(input int addr_w, input int len_w);
    return DESC_LEN_LSB + len_w + addr_w;
  endfunction

  function automatic int desc_width(input int id_w, input int addr_w, input int len_w);
    return id_w + addr_w + len_w + 5;
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/easyaxi_slv_rd_engine_addr_gen.sv
// easyaxi_addr_gen: combinational next-beat address calculator.
// Ports:
//   i_addr      current beat byte address
//   i_size      AxSIZE (bytes per beat = 1 << size)
//   i_len       AxLEN (beats - 1)
//   i_burst     AxBURST
//   o_next_addr address of the following beat (held when o_err)
//   o_err       descriptor is unsupported: reserved burst, illegal WRAP length,
//               or size wider than the data bus
module easyaxi_addr_gen
  import easyaxi_slv_rd_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic                  o_err
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_incr_addr;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic                  w_wrap_len_ok;

  always_comb begin
    w_bytes       = ADDR_WIDTH'(1) << i_size;
    w_incr_addr   = i_addr + w_bytes;
    // Wrap boundary is (len+1)*bytes; only power-of-two lengths are legal, so
    // the boundary is itself a power of two and the mask is boundary-1.
    w_wrap_mask   = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
    w_wrap_len_ok = (i_len == LEN_WIDTH'(1)) || (i_len == LEN_WIDTH'(3)) ||
                    (i_len == LEN_WIDTH'(7)) || (i_len == LEN_WIDTH'(15));

    o_err = (i_burst == 2'b11) ||
            ((i_burst == BURST_WRAP) && !w_wrap_len_ok) ||
            (i_size > MAX_SIZE);

    o_next_addr = i_addr;
    if (!o_err) begin
      case (i_burst)
        BURST_INCR: o_next_addr = w_incr_addr;
        BURST_WRAP: o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
        default:    o_next_addr = i_addr;
      endcase
    end
  end

endmodule

// File: rtl/easyaxi_slv_rd_engine.sv
// easyaxi_slv_rd_engine: pops read descriptors from the AR descriptor FIFO and
// streams each as a complete R-channel burst, reading a combinational memory port.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   desc_empty        descriptor FIFO empty
//   desc_data         head descriptor {id, addr, len, size, burst}
//   desc_pop          pop head descriptor (combinational)
//   mem_rd, mem_addr  memory read strobe / byte address (combinational)
//   mem_rdata         memory data, same-cycle response
//   rvalid..rlast     AXI R channel
//   dbg_state         current engine state
// R handshake: a beat transfers on rvalid & rready. The output register accepts a
// new beat whenever it is empty or being drained this cycle (slot free); while
// rvalid & ~rready all R outputs hold and no memory read is issued.
module easyaxi_slv_rd_engine
  import easyaxi_slv_rd_engine_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     desc_empty,
  input  logic [ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+4:0] desc_data,
  output logic                                     desc_pop,
  output logic                                     mem_rd,
  output logic [ADDR_WIDTH-1:0]                    mem_addr,
  input  logic [DATA_WIDTH-1:0]                    mem_rdata,
  output logic                                     rvalid,
  input  logic                                     rready,
  output logic [ID_WIDTH-1:0]                      rid,
  output logic [DATA_WIDTH-1:0]                    rdata,
  output logic [1:0]                               rresp,
  output logic                                     rlast,
  output state_t                                   dbg_state
);

  localparam int ADDR_LSB = desc_addr_lsb(LEN_WIDTH);
  localparam int ID_LSB   = desc_id_lsb(ADDR_WIDTH, LEN_WIDTH);

  // Head descriptor fields
  logic [ID_WIDTH-1:0]   w_d_id;
  logic [ADDR_WIDTH-1:0] w_d_addr;
  logic [LEN_WIDTH-1:0]  w_d_len;
  logic [2:0]            w_d_size;
  logic [1:0]            w_d_burst;

  assign w_d_burst = desc_data[DESC_BURST_LSB +: 2];
  assign w_d_size  = desc_data[DESC_SIZE_LSB +: 3];
  assign w_d_len   = desc_data[DESC_LEN_LSB +: LEN_WIDTH];
  assign w_d_addr  = desc_data[ADDR_LSB +: ADDR_WIDTH];
  assign w_d_id    = desc_data[ID_LSB +: ID_WIDTH];

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [ID_WIDTH-1:0]   r_id;

  logic                  w_slot_free;
  logic                  w_load;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_gen_addr;
  logic [LEN_WIDTH-1:0]  w_gen_len;
  logic [2:0]            w_gen_size;
  logic [1:0]            w_gen_burst;
  logic [ID_WIDTH-1:0]   w_beat_id;
  logic                  w_beat_last;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_err;

  assign w_slot_free = ~r_rvalid | rready;

  // In IDLE beat 0 is built straight from the head descriptor so the first beat
  // costs no extra cycle; in BURST the latched descriptor drives the calculator.
  easyaxi_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_addr_gen (
    .i_addr     (w_gen_addr),
    .i_size     (w_gen_size),
    .i_len      (w_gen_len),
    .i_burst    (w_gen_burst),
    .o_next_addr(w_next_addr),
    .o_err      (w_err)
  );

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_gen_addr   = r_addr;
    w_gen_len    = r_len;
    w_gen_size   = r_size;
    w_gen_burst  = r_burst;
    w_beat_id    = r_id;
    w_beat_last  = (r_beat_cnt == r_len);
    case (r_state)
      ST_IDLE: begin
        w_gen_addr  = w_d_addr;
        w_gen_len   = w_d_len;
        w_gen_size  = w_d_size;
        w_gen_burst = w_d_burst;
        w_beat_id   = w_d_id;
        w_beat_last = (w_d_len == '0);
        // rst_n gating keeps pop/read strobes quiet while reset is held.
        if (rst_n && !desc_empty && w_slot_free) begin
          w_load = 1'b1;
          w_pop  = 1'b1;
          if (w_d_len != '0) w_next_state = ST_BURST;
        end
      end
      ST_BURST: begin
        if (rst_n && w_slot_free) begin
          w_load = 1'b1;
          if (w_beat_last) w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign desc_pop  = w_pop;
  assign mem_rd    = w_load;
  assign mem_addr  = w_gen_addr;
  assign rvalid    = r_rvalid;
  assign rlast     = r_rlast;
  assign rid       = r_rid;
  assign rdata     = r_rdata;
  assign rresp     = r_rresp;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_id       <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_rvalid <= 1'b1;
        r_rdata  <= mem_rdata;
        r_rid    <= w_beat_id;
        r_rresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
        r_rlast  <= w_beat_last;
      end else if (rready) begin
        r_rvalid <= 1'b0;
      end
      if (w_load) begin
        if (r_state == ST_IDLE) begin
          r_id       <= w_d_id;
          r_len      <= w_d_len;
          r_size     <= w_d_size;
          r_burst    <= w_d_burst;
          r_addr     <= w_next_addr;
          r_beat_cnt <= LEN_WIDTH'(1);
        end else if (!w_beat_last) begin
          r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
          r_addr     <= w_next_addr;
        end
      end
    end
  end

endmodule

// File: doc/easyaxi_slv_rd_engine.md
Name: easyaxi_slv_rd_engine

Overview:
Slave-side AXI read-data engine. It sits directly downstream of the AR descriptor FIFO and pops one queued read descriptor at a time. For each descriptor it generates the full R-channel burst with INCR/FIXED/WRAP address sequencing, reading data from a combinational memory port. Back-to-back bursts are issued with no idle cycle between RLAST and the next burst's first beat.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, R data width; max size = log2(DATA_WIDTH/8)
LEN_WIDTH, 8, AxLEN width (beats-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
desc_empty  in  1  descriptor FIFO empty
desc_data  in  ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+5  head descriptor {id,addr,len,size[2:0],burst[1:0]}; valid while ~desc_empty
desc_pop  out  1  pop head descriptor (combinational)
mem_rd  out  1  memory read strobe (combinational, = beat load)
mem_addr  out  ADDR_WIDTH  memory byte address (combinational)
mem_rdata  in  DATA_WIDTH  memory data, same-cycle response to mem_addr
rvalid  out  1  R valid
rready  in  1  R ready
rid  out  ID_WIDTH  R ID
rdata  out  DATA_WIDTH  R data
rresp  out  2  R response
rlast  out  1  last beat of burst

Behaviour:
- Reset: state=IDLE; rvalid, rlast, rid, rdata, rresp, beat counter, address/len/size/burst/id registers all 0. desc_pop=0 and mem_rd=0 while in reset. A burst interrupted by reset is abandoned; its remaining beats are not regenerated.
- slot_free = ~rvalid | rready. A beat load writes the R output register from mem_rdata at mem_addr.
- IDLE:
  - If ~desc_empty & slot_free: desc_pop=1, mem_rd=1, mem_addr=desc addr; load beat 0 using desc_data fields directly.
  - If len==0, stay IDLE with rlast=1. Otherwise latch id/len/size/burst and next address, beat_cnt=1, go BURST.
  - If the slot is not free, do not pop.
- BURST:
  - On slot_free: mem_rd=1, load beat beat_cnt at cur_addr; rlast=(beat_cnt==len).
  - On the last beat go IDLE; otherwise beat_cnt++ and advance the address.
  - No pop in BURST.
- Latency: descriptor visible with slot free -> rvalid high the next cycle.
- rvalid clears on rvalid&rready when no beat is loaded the same cycle.
- Stall: while rvalid & ~rready, rid/rdata/rresp/rlast hold stable and no mem_rd is issued.
- Address arithmetic: bytes=1<<size.
  - INCR: addr+bytes, wraps modulo 2^ADDR_WIDTH.
  - FIXED: addr held.
  - WRAP: wb=(len+1)*bytes; next=(addr & ~(wb-1)) | ((addr+bytes) & (wb-1)).
- Error handling:
  - Reserved burst 2'b11, or WRAP with len not in {1,3,7,15}: all beats carry rresp=2'b10 (SLVERR), the address is held, and the full beat count is still generated.
  - size > log2(DATA_WIDTH/8): SLVERR, same handling.
  - Otherwise rresp=2'b00.
- rdata is passed unmodified from mem_rdata; no lane masking.
- desc_pop is never asserted while desc_empty=1.

Decomposition:
- Shared package: BURST_FIXED/INCR/WRAP encodings, RESP_OKAY/SLVERR, descriptor field offsets and total width, state encoding (IDLE, BURST).
- One natural sub-module: easyaxi_addr_gen, combinational next-address calculator (addr, size, len, burst -> next_addr, err).

Test Plan:
1. INCR id=3 addr=0x100 len=3 size=2, rready=1 -> 4 beats at mem_addr 0x100, 0x104, 0x108, 0x10C; rid=3; rlast only on beat 4; rresp=0.
2. WRAP addr=0x108 len=3 size=2 -> mem_addr 0x108, 0x10C, 0x100, 0x104; rlast on 4th beat.
3. FIXED addr=0x40 len=2 -> 3 beats, all at mem_addr 0x40; rlast on 3rd beat.
4. INCR len=3 with rready low for 5 cycles at beat 1 -> rvalid and rdata/rid/rlast stable, mem_rd=0 during the stall, then beats resume in order with no beat lost.
5. Two queued descriptors (len=1 each), rready=1 -> 4 consecutive rvalid cycles; desc_pop in the cycle beat 2 is accepted; beat 1 of the second burst follows with no bubble.
6. burst=2'b11 len=1 -> 2 beats, rresp=2'b10, same address. Also: rst_n asserted mid-burst -> rvalid=0 immediately and no further beats after release until a new descriptor arrives.
